// File: rtl/sha256_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sha256_pkg                                                            |
// | Shared constants and types for the SHA-256 header feeder.             |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package sha256_pkg;

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    // Message lengths in bits, written into the last 64 bits of a padded block
    localparam logic [63:0] LEN_640 = 64'd640;
    localparam logic [63:0] LEN_256 = 64'd256;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        WAIT0  = 3'd2,
        ISSUE1 = 3'd3,
        WAIT1  = 3'd4,
        ISSUE2 = 3'd5,
        WAIT2  = 3'd6,
        DONE   = 3'd7
    } state_t;

    typedef enum logic [0:0] {
        PAD_640 = 1'b0,
        PAD_256 = 1'b1
    } len_sel_t;

endpackage
`default_nettype wire

// File: rtl/sha256_header_feeder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sha256_header_feeder_if                                               |
// | Link between the header feeder (master) and the sha256 core (slave).  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface sha256_header_feeder_if;

    logic         core_enable;
    logic [511:0] core_data;
    logic [255:0] core_current_hash;
    logic [255:0] core_hash;
    logic         core_hash_done;

    modport master (
        output core_enable,
        output core_data,
        output core_current_hash,
        input  core_hash,
        input  core_hash_done
    );

    modport slave (
        input  core_enable,
        input  core_data,
        input  core_current_hash,
        output core_hash,
        output core_hash_done
    );

endinterface
`default_nettype wire

// File: rtl/sha256_pad.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sha256_pad                                                            |
// | Combinational builder of the final padded 512-bit block.              |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sha256_pad
    import sha256_pkg::*;
(
    input  logic [127:0] tail_i,
    input  logic [255:0] chain_i,
    input  len_sel_t     sel_i,
    output logic [511:0] block_o
);

    always_comb begin
        block_o = {tail_i, 1'b1, 319'b0, LEN_640};
        if (sel_i == PAD_256) begin
            block_o = {chain_i, 1'b1, 191'b0, LEN_256};
        end
    end

endmodule
`default_nettype wire

// File: rtl/sha256_header_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sha256_header_feeder                                                  |
// | Splits an 80-octet header into padded blocks and sequences the core.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sha256_header_feeder
    import sha256_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic                  dbl,
    input  logic [639:0]          msg,
    output logic                  busy,
    output logic [255:0]          digest,
    output logic                  digest_valid,
    output logic                  error,
    sha256_header_feeder_if.master core
);

    localparam int             CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [127:0]       tail_q,   tail_d;
    logic               dbl_q,    dbl_d;
    logic [511:0]       data_q,   data_d;
    logic [255:0]       chash_q,  chash_d;
    logic [255:0]       digest_q, digest_d;

    logic [511:0]       pad_block;
    len_sel_t           pad_sel;
    logic               expire;

    // Only the WAIT1 exit builds the re-hash block; WAIT0 builds the header tail
    assign pad_sel = (state_q == WAIT1) ? PAD_256 : PAD_640;
    assign expire  = ((cnt_q + CNT_W'(1)) == CNT_LIMIT);

    sha256_pad u_pad (
        .tail_i  (tail_q),
        .chain_i (core.core_hash),
        .sel_i   (pad_sel),
        .block_o (pad_block)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tail_q   <= '0;
            dbl_q    <= 1'b0;
            data_q   <= '0;
            chash_q  <= '0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tail_q   <= tail_d;
            dbl_q    <= dbl_d;
            data_q   <= data_d;
            chash_q  <= chash_d;
            digest_q <= digest_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tail_d   = tail_q;
        dbl_d    = dbl_q;
        data_d   = data_q;
        chash_d  = chash_q;
        digest_d = digest_q;
        error    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tail_d  = msg[127:0];
                    dbl_d   = dbl;
                    data_d  = msg[639:128];
                    chash_d = IV;
                    state_d = ISSUE0;
                end
            end
            ISSUE0: begin
                cnt_d   = '0;
                state_d = WAIT0;
            end
            ISSUE1: begin
                cnt_d   = '0;
                state_d = WAIT1;
            end
            ISSUE2: begin
                cnt_d   = '0;
                state_d = WAIT2;
            end
            WAIT0: begin
                if (core.core_hash_done) begin
                    data_d  = pad_block;
                    chash_d = core.core_hash;
                    state_d = ISSUE1;
                end else if (expire) begin
                    error   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT1: begin
                if (core.core_hash_done) begin
                    if (dbl_q) begin
                        data_d  = pad_block;
                        chash_d = IV;
                        state_d = ISSUE2;
                    end else begin
                        digest_d = core.core_hash;
                        state_d  = DONE;
                    end
                end else if (expire) begin
                    error   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT2: begin
                if (core.core_hash_done) begin
                    digest_d = core.core_hash;
                    state_d  = DONE;
                end else if (expire) begin
                    error   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy                   = (state_q != IDLE);
    assign digest                 = digest_q;
    assign digest_valid           = (state_q == DONE);
    assign core.core_enable       = (state_q == ISSUE0) || (state_q == ISSUE1) ||
                                    (state_q == ISSUE2);
    assign core.core_data         = data_q;
    assign core.core_current_hash = chash_q;

endmodule
`default_nettype wire

// File: doc/sha256_header_feeder.md
# sha256_header_feeder

Front-end sequencer for the `sha256` compression core. It accepts one 640-bit (80-octet) block header and splits and pads it into two 512-bit blocks, then issues them to the core in turn, chaining the intermediate hash. In double-hash mode it also issues a third, padded 256-bit block that re-hashes the first digest. It sits directly upstream of `sha256`, drives that core's `enable`, `data` and `current_hash`, and consumes its `hash` and `hash_done`.

## Interface
- `TIMEOUT`, 255: maximum cycles allowed between a `core_enable` pulse and `core_hash_done` before the job aborts.
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle job request. Ignored while `busy` is high.
- `dbl` in 1: sampled with `start`. 1 selects SHA256d (hash of the hash).
- `msg` in 640: header, first octet in `msg[639:632]`. Sampled with `start`.
- `busy` out 1: a job is in flight.
- `digest` out 256: final hash, held until the next job completes.
- `digest_valid` out 1: one-cycle pulse when `digest` updates.
- `error` out 1: one-cycle pulse on timeout.
- `core_enable` out 1: one-cycle pulse to `sha256.enable`.
- `core_data` out 512: to `sha256.data`.
- `core_current_hash` out 256: to `sha256.current_hash`.
- `core_hash` in 256: from `sha256.hash`. This is the full chained output, with the feed-forward addition already applied by the core.
- `core_hash_done` in 1: from `sha256.hash_done`, a one-cycle pulse.

## Operation
- **States:** IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE.
- **IDLE:** on `start`, register `msg` and `dbl`, then go to ISSUE0.
- **ISSUE0 (one cycle):**
  - `core_enable`=1.
  - `core_data`=`msg[639:128]`.
  - `core_current_hash`=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - Next state: WAIT0.
- **WAIT0:** on `core_hash_done`, register `core_hash` as the chain value and go to ISSUE1.
- **ISSUE1:**
  - `core_data`=`{msg[127:0], 1'b1, 319'b0, 64'd640}`.
  - `core_current_hash`=chain value.
  - Next state: WAIT1.
- **WAIT1:** on `core_hash_done`:
  - if `dbl`=0, register `core_hash` into `digest` and go to DONE;
  - if `dbl`=1, register `core_hash` as the chain value and go to ISSUE2.
- **ISSUE2:**
  - `core_data`=`{chain, 1'b1, 191'b0, 64'd256}`.
  - `core_current_hash`=IV.
  - Next state: WAIT2.
- **WAIT2:** on `core_hash_done`, register `core_hash` into `digest` and go to DONE.
- **DONE (one cycle):** `digest_valid`=1, then go to IDLE.
- **Operand stability:** `core_data` and `core_current_hash` are registered. They hold from the ISSUE cycle until the matching `core_hash_done`.
- **Timeout counter:**
  - cleared in every ISSUE state and incremented in every WAIT state;
  - when it reaches `TIMEOUT` with no `core_hash_done`, pulse `error`, go to IDLE and leave `digest` unchanged;
  - width is `$clog2(TIMEOUT+1)`.
- **Boundary conditions:**
  - `start` in any non-IDLE state, including DONE, is ignored.
  - `core_hash_done` outside a WAIT state is ignored.
  - `core_hash_done` in the same cycle the counter reaches `TIMEOUT`: completion wins.
- **Reset (including mid-job):** state IDLE, counter 0, every output 0 (`busy`, `digest`, `digest_valid`, `error`, `core_enable`, `core_data`, `core_current_hash`).

## Timing
- `start` is sampled at edge 0, and `core_enable` is high during cycle 1.
- ISSUE1 follows the `core_hash_done` cycle by exactly one cycle. The same holds for ISSUE2.
- `digest_valid` is high in the cycle after the final `core_hash_done`.
- `busy` goes high in cycle 1 and falls in the cycle after `digest_valid` or `error`.
- Total latency is 3 + N0 + N1 cycles for a single hash, and 4 + N0 + N1 + N2 for a double hash, where Nk is the core latency from the enable cycle to `hash_done`.

## Structure
- `sha256_pkg` holds:
  - the IV constant;
  - the state enum;
  - length words `LEN_640=64'd640` and `LEN_256=64'd256`.
- Sub-module `sha256_pad` is purely combinational. It builds the final padded block from the tail bits and a length select. The FSM, counter and registers stay in `sha256_header_feeder`.

## Test plan
- **All-zero `msg`, `dbl`=0, behavioural core with 65-cycle latency:** the first `core_data` is 512'b0 with IV. The second is 128'b0 & 1 & 319'b0 & 0x280 with `core_current_hash` equal to block-0 `hash`. `digest` equals the reference SHA256 of 80 zero octets.
- **Bitcoin genesis header, `dbl`=1:**
  - stimulus: 01000000, 32 zero octets, 3ba3edfd…4b1e5e4a, 29ab5f49, ffff001d, 1dac2b7c;
  - required response: `digest` = 6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000 and three `core_enable` pulses.
- **`start` re-pulsed during WAIT1 and during DONE:** ignored, and exactly one `digest_valid` per accepted job.
- **Core never asserts `hash_done`, `TIMEOUT`=16:** `error` pulses 16 cycles after `core_enable`, `busy` drops, and the previous `digest` is retained.
- **`n_rst` low during WAIT0:** all outputs 0 immediately. A following `start` runs a clean job matching the first test.
- **Spurious `core_hash_done` in IDLE:** no state change and no output change.
